// File: rtl/float_mult_arbiter.sv
// Round-robin arbiter sharing one float multiplier between two requesters; A/B/Z pass through as bit-exact copies.
// Latency: grant to result strobe is 3 cycles plus multiplier time; both handshakes stall indefinitely, strobes outside IDLE wait.
module float_mult_arbiter (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic [31:0] i_REQ0_A,
    input  logic [31:0] i_REQ0_B,
    input  logic        i_REQ0_AB_STB,
    output logic        o_REQ0_AB_ACK,
    output logic [31:0] o_REQ0_Z,
    output logic        o_REQ0_Z_STB,
    input  logic        i_REQ0_Z_ACK,
    input  logic [31:0] i_REQ1_A,
    input  logic [31:0] i_REQ1_B,
    input  logic        i_REQ1_AB_STB,
    output logic        o_REQ1_AB_ACK,
    output logic [31:0] o_REQ1_Z,
    output logic        o_REQ1_Z_STB,
    input  logic        i_REQ1_Z_ACK,
    output logic [31:0] o_MULT_A,
    output logic [31:0] o_MULT_B,
    output logic        o_MULT_AB_STB,
    input  logic        i_MULT_AB_ACK,
    input  logic [31:0] i_MULT_Z,
    input  logic        i_MULT_Z_STB,
    output logic        o_MULT_Z_ACK,
    output logic [1:0]  o_GRANT,
    output logic        o_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_Z = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic [1:0]  r_grant;
    logic [31:0] r_mult_a;
    logic [31:0] r_mult_b;
    logic [31:0] r_z0;
    logic [31:0] r_z1;
    logic        r_mult_ab_stb;
    logic        r_mult_z_ack;
    logic        r_ab_ack0;
    logic        r_ab_ack1;
    logic        r_z_stb0;
    logic        r_z_stb1;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick1;
    logic        w_z_ack;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    always_comb begin
        w_any_req = i_REQ0_AB_STB | i_REQ1_AB_STB;
        w_pick1   = i_REQ1_AB_STB & (~i_REQ0_AB_STB | ~r_last);
        w_z_ack   = r_grant[1] ? i_REQ1_Z_ACK : (r_grant[0] & i_REQ0_Z_ACK);
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            r_state       <= ST_IDLE;
            r_last        <= 1'b1;
            r_grant       <= 2'b00;
            r_mult_a      <= 32'd0;
            r_mult_b      <= 32'd0;
            r_z0          <= 32'd0;
            r_z1          <= 32'd0;
            r_mult_ab_stb <= 1'b0;
            r_mult_z_ack  <= 1'b0;
            r_ab_ack0     <= 1'b0;
            r_ab_ack1     <= 1'b0;
            r_z_stb0      <= 1'b0;
            r_z_stb1      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_ab_ack0    <= 1'b0;
            r_ab_ack1    <= 1'b0;
            r_mult_z_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant       <= w_pick1 ? 2'b10 : 2'b01;
                        r_mult_a      <= w_pick1 ? i_REQ1_A : i_REQ0_A;
                        r_mult_b      <= w_pick1 ? i_REQ1_B : i_REQ0_B;
                        r_ab_ack0     <= ~w_pick1;
                        r_ab_ack1     <= w_pick1;
                        r_mult_ab_stb <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_mult_ab_stb && i_MULT_AB_ACK) begin
                        r_mult_ab_stb <= 1'b0;
                        r_state       <= ST_WAIT_Z;
                    end else begin
                        r_mult_ab_stb <= 1'b1;
                    end
                end
                ST_WAIT_Z: begin
                    if (i_MULT_Z_STB) begin
                        if (r_grant[1]) begin
                            r_z1 <= i_MULT_Z;
                        end else begin
                            r_z0 <= i_MULT_Z;
                        end
                        r_mult_z_ack <= 1'b1;
                        r_z_stb0     <= r_grant[0];
                        r_z_stb1     <= r_grant[1];
                        r_state      <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (w_z_ack) begin
                        r_z_stb0 <= 1'b0;
                        r_z_stb1 <= 1'b0;
                        r_last   <= r_grant[1];
                        r_grant  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_mult_ab_stb <= 1'b0;
                    r_z_stb0      <= 1'b0;
                    r_z_stb1      <= 1'b0;
                    r_grant       <= 2'b00;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_REQ0_AB_ACK = r_ab_ack0;
    assign o_REQ1_AB_ACK = r_ab_ack1;
    assign o_REQ0_Z      = r_z0;
    assign o_REQ1_Z      = r_z1;
    assign o_REQ0_Z_STB  = r_z_stb0;
    assign o_REQ1_Z_STB  = r_z_stb1;
    assign o_MULT_A      = r_mult_a;
    assign o_MULT_B      = r_mult_b;
    assign o_MULT_AB_STB = r_mult_ab_stb;
    assign o_MULT_Z_ACK  = r_mult_z_ack;
    assign o_GRANT       = r_grant;
    assign o_BUSY        = r_busy;

endmodule

// File: tb/tb_float_mult_arbiter.sv
// Directed bench for float_mult_arbiter with a behavioural multiplier answering from a table of known products.
module tb_float_mult_arbiter;

    logic        i_CLK = 1'b0;
    logic        i_RSTN;
    logic [31:0] i_REQ0_A, i_REQ0_B, i_REQ1_A, i_REQ1_B;
    logic        i_REQ0_AB_STB, i_REQ1_AB_STB;
    logic        o_REQ0_AB_ACK, o_REQ1_AB_ACK;
    logic [31:0] o_REQ0_Z, o_REQ1_Z;
    logic        o_REQ0_Z_STB, o_REQ1_Z_STB;
    logic        i_REQ0_Z_ACK, i_REQ1_Z_ACK;
    logic [31:0] o_MULT_A, o_MULT_B, i_MULT_Z;
    logic        o_MULT_AB_STB, i_MULT_AB_ACK, i_MULT_Z_STB, o_MULT_Z_ACK;
    logic [1:0]  o_GRANT;
    logic        o_BUSY;

    int checks   = 0;
    int failures = 0;
    int m_ack_delay = 0;
    int m_z_delay   = 1;

    always #5 i_CLK = ~i_CLK;

    float_mult_arbiter dut (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN),
        .i_REQ0_A(i_REQ0_A), .i_REQ0_B(i_REQ0_B), .i_REQ0_AB_STB(i_REQ0_AB_STB),
        .o_REQ0_AB_ACK(o_REQ0_AB_ACK), .o_REQ0_Z(o_REQ0_Z), .o_REQ0_Z_STB(o_REQ0_Z_STB),
        .i_REQ0_Z_ACK(i_REQ0_Z_ACK),
        .i_REQ1_A(i_REQ1_A), .i_REQ1_B(i_REQ1_B), .i_REQ1_AB_STB(i_REQ1_AB_STB),
        .o_REQ1_AB_ACK(o_REQ1_AB_ACK), .o_REQ1_Z(o_REQ1_Z), .o_REQ1_Z_STB(o_REQ1_Z_STB),
        .i_REQ1_Z_ACK(i_REQ1_Z_ACK),
        .o_MULT_A(o_MULT_A), .o_MULT_B(o_MULT_B), .o_MULT_AB_STB(o_MULT_AB_STB),
        .i_MULT_AB_ACK(i_MULT_AB_ACK), .i_MULT_Z(i_MULT_Z), .i_MULT_Z_STB(i_MULT_Z_STB),
        .o_MULT_Z_ACK(o_MULT_Z_ACK),
        .o_GRANT(o_GRANT), .o_BUSY(o_BUSY)
    );

    function automatic logic [31:0] fprod(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3F800000 && b == 32'hBF800000) return 32'hBF800000;
        if (a == 32'h40800000 && b == 32'h3F000000) return 32'h40000000;
        return 32'hDEADBEEF;
    endfunction

    // Multiplier model: acks operands after m_ack_delay cycles, returns the product m_z_delay cycles later.
    initial begin : mult_model
        int          st;
        int          cnt;
        logic [31:0] prod;
        st = 0; cnt = 0; prod = 32'd0;
        i_MULT_AB_ACK = 1'b0; i_MULT_Z_STB = 1'b0; i_MULT_Z = 32'd0;
        forever begin
            @(posedge i_CLK); #1;
            if (!i_RSTN) begin
                st = 0; cnt = 0; i_MULT_AB_ACK = 1'b0; i_MULT_Z_STB = 1'b0;
            end else begin
                case (st)
                    0: if (o_MULT_AB_STB) begin
                        if (cnt >= m_ack_delay) begin
                            i_MULT_AB_ACK = 1'b1;
                            prod = fprod(o_MULT_A, o_MULT_B);
                            st = 1;
                        end else begin
                            cnt++;
                        end
                    end
                    1: begin i_MULT_AB_ACK = 1'b0; cnt = 0; st = 2; end
                    2: begin
                        cnt++;
                        if (cnt >= m_z_delay) begin i_MULT_Z = prod; i_MULT_Z_STB = 1'b1; st = 3; end
                    end
                    3: if (o_MULT_Z_ACK) begin i_MULT_Z_STB = 1'b0; cnt = 0; st = 0; end
                    default: st = 0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_zstb(input int n, input string tag);
        int k = 0;
        while (((n == 0) ? o_REQ0_Z_STB : o_REQ1_Z_STB) !== 1'b1 && k < 100) begin
            @(negedge i_CLK);
            k++;
        end
        check(tag, 32'(k < 100), 32'd1);
    endtask

    task automatic wait_grant(output logic [1:0] g);
        int k = 0;
        while (o_GRANT === 2'b00 && k < 100) begin
            @(negedge i_CLK);
            k++;
        end
        g = o_GRANT;
        check("grant_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic ack_z(input int n);
        if (n == 0) i_REQ0_Z_ACK = 1'b1; else i_REQ1_Z_ACK = 1'b1;
        @(negedge i_CLK);
        i_REQ0_Z_ACK = 1'b0;
        i_REQ1_Z_ACK = 1'b0;
    endtask

    initial begin : stim
        logic [1:0] g;
        int         saw;
        i_RSTN = 1'b0;
        i_REQ0_A = 32'd0; i_REQ0_B = 32'd0; i_REQ1_A = 32'd0; i_REQ1_B = 32'd0;
        i_REQ0_AB_STB = 1'b0; i_REQ1_AB_STB = 1'b0;
        i_REQ0_Z_ACK = 1'b0; i_REQ1_Z_ACK = 1'b0;
        repeat (3) @(negedge i_CLK);

        // Reset state
        check("rst_grant", 32'(o_GRANT), 32'd0);
        check("rst_busy", 32'(o_BUSY), 32'd0);
        check("rst_mult_a", o_MULT_A, 32'd0);
        check("rst_mult_ab_stb", 32'(o_MULT_AB_STB), 32'd0);
        check("rst_z0", o_REQ0_Z, 32'd0);
        check("rst_z_stb0", 32'(o_REQ0_Z_STB), 32'd0);
        check("rst_ab_ack0", 32'(o_REQ0_AB_ACK), 32'd0);
        i_RSTN = 1'b1;
        @(negedge i_CLK);
        check("idle_after_rst_busy", 32'(o_BUSY), 32'd0);

        // Lone request from req0: 2.0 * 3.0
        i_REQ0_A = 32'h40000000; i_REQ0_B = 32'h40400000; i_REQ0_AB_STB = 1'b1;
        @(negedge i_CLK);
        check("t1_ab_ack0", 32'(o_REQ0_AB_ACK), 32'd1);
        check("t1_ab_ack1", 32'(o_REQ1_AB_ACK), 32'd0);
        check("t1_grant", 32'(o_GRANT), 32'd1);
        check("t1_busy", 32'(o_BUSY), 32'd1);
        check("t1_mult_a", o_MULT_A, 32'h40000000);
        check("t1_mult_b", o_MULT_B, 32'h40400000);
        i_REQ0_AB_STB = 1'b0;
        @(negedge i_CLK);
        check("t1_ab_ack0_pulse", 32'(o_REQ0_AB_ACK), 32'd0);
        wait_zstb(0, "t1_z0_timeout");
        check("t1_z0", o_REQ0_Z, 32'h40C00000);
        check("t1_z_stb1", 32'(o_REQ1_Z_STB), 32'd0);
        check("t1_z1", o_REQ1_Z, 32'd0);
        ack_z(0);
        check("t1_done_grant", 32'(o_GRANT), 32'd0);
        check("t1_done_zstb0", 32'(o_REQ0_Z_STB), 32'd0);
        check("t1_done_busy", 32'(o_BUSY), 32'd0);

        // Fresh reset, then both strobe together: req0 wins the first tie
        i_RSTN = 1'b0;
        repeat (2) @(negedge i_CLK);
        i_RSTN = 1'b1;
        i_REQ0_A = 32'h40000000; i_REQ0_B = 32'h40400000;
        i_REQ1_A = 32'h3F800000; i_REQ1_B = 32'hBF800000;
        i_REQ0_AB_STB = 1'b1; i_REQ1_AB_STB = 1'b1;
        @(negedge i_CLK);
        check("t2_grant_first", 32'(o_GRANT), 32'd1);
        check("t2_ab_ack0", 32'(o_REQ0_AB_ACK), 32'd1);
        check("t2_ab_ack1_first", 32'(o_REQ1_AB_ACK), 32'd0);
        i_REQ0_AB_STB = 1'b0;
        wait_zstb(0, "t2_z0_timeout");
        check("t2_z0", o_REQ0_Z, 32'h40C00000);
        check("t2_ab_ack1_blocked", 32'(o_REQ1_AB_ACK), 32'd0);
        ack_z(0);
        check("t2_grant_gap", 32'(o_GRANT), 32'd0);
        @(negedge i_CLK);
        check("t2_grant_second", 32'(o_GRANT), 32'd2);
        check("t2_ab_ack1", 32'(o_REQ1_AB_ACK), 32'd1);
        check("t2_mult_a", o_MULT_A, 32'h3F800000);
        i_REQ1_AB_STB = 1'b0;
        wait_zstb(1, "t2_z1_timeout");
        check("t2_z1", o_REQ1_Z, 32'hBF800000);
        check("t2_z_stb0", 32'(o_REQ0_Z_STB), 32'd0);
        check("t2_z0_kept", o_REQ0_Z, 32'h40C00000);
        ack_z(1);
        check("t2_grant_end", 32'(o_GRANT), 32'd0);

        // req1 holds its strobe, req0 re-strobes after each completion: strict alternation
        i_REQ0_AB_STB = 1'b1; i_REQ1_AB_STB = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_grant(g);
            check("t3_grant_order", 32'(g), (t % 2 == 0) ? 32'd1 : 32'd2);
            if (g == 2'b01) begin
                i_REQ0_AB_STB = 1'b0;
                wait_zstb(0, "t3_z0_timeout");
                check("t3_z0", o_REQ0_Z, 32'h40C00000);
            end else begin
                wait_zstb(1, "t3_z1_timeout");
                check("t3_z1", o_REQ1_Z, 32'hBF800000);
            end
            if (t == 3) begin
                i_REQ0_AB_STB = 1'b0;
                i_REQ1_AB_STB = 1'b0;
            end
            ack_z((g == 2'b10) ? 1 : 0);
            i_REQ0_AB_STB = (t < 3);
        end

        // Result ack withheld by req0 while req1 waits: 4.0 * 0.5
        i_REQ0_A = 32'h40800000; i_REQ0_B = 32'h3F000000;
        i_REQ0_AB_STB = 1'b1; i_REQ1_AB_STB = 1'b1;
        @(negedge i_CLK);
        check("t4_grant", 32'(o_GRANT), 32'd1);
        i_REQ0_AB_STB = 1'b0;
        wait_zstb(0, "t4_z0_timeout");
        check("t4_z0", o_REQ0_Z, 32'h40000000);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_CLK);
            check("t4_zstb_held", 32'(o_REQ0_Z_STB), 32'd1);
            check("t4_z0_stable", o_REQ0_Z, 32'h40000000);
            check("t4_ab_ack1_wait", 32'(o_REQ1_AB_ACK), 32'd0);
        end
        ack_z(0);
        check("t4_grant_gap", 32'(o_GRANT), 32'd0);
        @(negedge i_CLK);
        check("t4_grant_req1", 32'(o_GRANT), 32'd2);
        check("t4_ab_ack1", 32'(o_REQ1_AB_ACK), 32'd1);
        i_REQ1_AB_STB = 1'b0;
        wait_zstb(1, "t4_z1_timeout");
        check("t4_z1", o_REQ1_Z, 32'hBF800000);
        ack_z(1);

        // Multiplier stalls operand ack for 3 cycles
        m_ack_delay = 3;
        i_REQ0_AB_STB = 1'b1;
        @(negedge i_CLK);
        check("t5_grant", 32'(o_GRANT), 32'd1);
        i_REQ0_AB_STB = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_stb_held", 32'(o_MULT_AB_STB), 32'd1);
            check("t5_mult_a", o_MULT_A, 32'h40800000);
            check("t5_mult_b", o_MULT_B, 32'h3F000000);
            @(negedge i_CLK);
        end
        check("t5_stb_at_ack", 32'(o_MULT_AB_STB), 32'd1);
        @(negedge i_CLK);
        check("t5_stb_dropped", 32'(o_MULT_AB_STB), 32'd0);
        check("t5_mult_a_wait", o_MULT_A, 32'h40800000);
        wait_zstb(0, "t5_z0_timeout");
        check("t5_z0", o_REQ0_Z, 32'h40000000);
        ack_z(0);
        m_ack_delay = 0;

        // Reset pulse while waiting on the product
        m_z_delay = 10;
        i_REQ0_A = 32'h40000000; i_REQ0_B = 32'h40400000; i_REQ0_AB_STB = 1'b1;
        @(negedge i_CLK);
        check("t6_grant", 32'(o_GRANT), 32'd1);
        i_REQ0_AB_STB = 1'b0;
        @(negedge i_CLK);
        check("t6_wait_stb", 32'(o_MULT_AB_STB), 32'd0);
        check("t6_wait_busy", 32'(o_BUSY), 32'd1);
        i_RSTN = 1'b0;
        @(negedge i_CLK);
        i_RSTN = 1'b1;
        m_z_delay = 1;
        check("t6_rst_grant", 32'(o_GRANT), 32'd0);
        check("t6_rst_busy", 32'(o_BUSY), 32'd0);
        check("t6_rst_mult_a", o_MULT_A, 32'd0);
        check("t6_rst_mult_b", o_MULT_B, 32'd0);
        check("t6_rst_mult_z_ack", 32'(o_MULT_Z_ACK), 32'd0);
        check("t6_rst_z0", o_REQ0_Z, 32'd0);
        check("t6_rst_z1", o_REQ1_Z, 32'd0);
        check("t6_rst_z_stb0", 32'(o_REQ0_Z_STB), 32'd0);
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_CLK);
            if (o_REQ0_Z_STB !== 1'b0 || o_REQ1_Z_STB !== 1'b0 || o_BUSY !== 1'b0) saw++;
        end
        check("t6_no_result_after_abort", 32'(saw), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_mult_arbiter.md
FLOAT_MULT_ARBITER -- requirements
Module: float_mult_arbiter

Interface
REQ-001 SHALL have i_CLK  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have i_RSTN  input  1  reset; synchronous, active-low (sampled only on i_CLK rising edge).
REQ-003 SHALL have, for n in {0,1}: i_REQn_A / i_REQn_B  input  32  float operands.
REQ-004 SHALL have, for n in {0,1}: i_REQn_AB_STB  input  1  operands valid; o_REQn_AB_ACK  output  1  operands taken.
REQ-005 SHALL have, for n in {0,1}: o_REQn_Z  output  32  product; o_REQn_Z_STB  output  1  product valid; i_REQn_Z_ACK  input  1  product taken.
REQ-006 SHALL have multiplier master port: o_MULT_A, o_MULT_B  output  32; o_MULT_AB_STB  output  1; i_MULT_AB_ACK  input  1; i_MULT_Z  input  32; i_MULT_Z_STB  input  1; o_MULT_Z_ACK  output  1.
REQ-007 SHALL have o_GRANT  output  2  one-hot owner (bit n = requester n); 2'b00 when idle.
REQ-008 SHALL have o_BUSY  output  1  high in every state except ST_IDLE.

Function
REQ-009 SHALL implement states ST_IDLE, ST_ISSUE, ST_WAIT_Z, ST_RETURN; all other encodings -> ST_IDLE next cycle.
REQ-010 SHALL, in ST_IDLE with at least one i_REQn_AB_STB high, grant one requester, latch its A/B into o_MULT_A/o_MULT_B, pulse o_REQn_AB_ACK high for exactly one cycle, set o_GRANT, and move to ST_ISSUE.
REQ-011 SHALL arbitrate round-robin: single requester wins; when both request, the requester not granted last wins; the last-granted pointer resets to 1 so requester 0 wins the first tie.
REQ-012 SHALL, in ST_ISSUE, drive o_MULT_AB_STB high while i_MULT_AB_ACK is low; on the first cycle where o_MULT_AB_STB and i_MULT_AB_ACK are both high, drop o_MULT_AB_STB next cycle and move to ST_WAIT_Z.
REQ-013 SHALL hold o_MULT_A/o_MULT_B constant from grant until leaving ST_WAIT_Z.
REQ-014 SHALL, in ST_WAIT_Z when i_MULT_Z_STB is high, capture i_MULT_Z into the granted requester's o_REQn_Z, pulse o_MULT_Z_ACK high for exactly one cycle, and move to ST_RETURN.
REQ-015 SHALL, in ST_RETURN, hold o_REQn_Z_STB high for the granted requester and low for the other; when i_REQn_Z_ACK is high, drop o_REQn_Z_STB next cycle, update the last-granted pointer, clear o_GRANT, and return to ST_IDLE.
REQ-016 SHALL hold o_REQn_Z stable from capture until the next capture for the same requester.
REQ-017 SHALL ignore both i_REQn_AB_STB in every state except ST_IDLE; a pending request is neither acknowledged nor lost and is served on a later ST_IDLE visit.
REQ-018 SHALL ignore i_REQn_Z_ACK from the non-granted requester, and ignore i_MULT_Z_STB outside ST_WAIT_Z.
REQ-019 SHALL give a minimum transaction latency (grant to o_REQn_Z_STB) of 3 cycles plus the multiplier compute time; the next grant is possible one cycle after ST_RETURN exits.
REQ-020 SHALL never pass operands through arithmetically; A/B/Z are bit-exact 32-bit copies.

Reset
REQ-021 SHALL, on i_CLK edge with i_RSTN low, force ST_IDLE, last-granted pointer = 1, and all outputs to 0 (o_MULT_A/B, o_MULT_AB_STB, o_MULT_Z_ACK, o_REQn_AB_ACK, o_REQn_Z, o_REQn_Z_STB, o_GRANT, o_BUSY).
REQ-022 SHALL, on reset mid-transaction in any state, abandon the transaction without emitting o_REQn_Z_STB; the multiplier is reset from the same i_RSTN.
REQ-023 SHALL keep every output at its reset value for the first cycle after i_RSTN returns high unless a request is already present, in which case REQ-010 applies on that cycle.

Verification
REQ-024 SHALL cover: req0 A=0x40000000, B=0x40400000 alone -> o_REQ0_AB_ACK one-cycle pulse, o_GRANT=01, o_REQ0_Z=0x40C00000 with o_REQ0_Z_STB, req1 outputs untouched.
REQ-025 SHALL cover: both requesters strobe in the same cycle after reset (req1 A=0x3F800000, B=0xBF800000) -> req0 served first, then req1 returns o_REQ1_Z=0xBF800000; o_GRANT sequence 01,00,10,00.
REQ-026 SHALL cover: req0 re-strobes immediately after each completion while req1 holds its strobe -> grants strictly alternate 0,1,0,1 over 4 transactions.
REQ-027 SHALL cover: i_REQ0_Z_ACK withheld 5 cycles -> o_REQ0_Z_STB held high 5+ cycles, o_REQ0_Z stable, req1 not acknowledged until req0 acks.
REQ-028 SHALL cover: multiplier i_MULT_AB_ACK low for 3 cycles in ST_ISSUE -> o_MULT_AB_STB held high throughout, operands unchanged.
REQ-029 SHALL cover: i_RSTN low for one cycle during ST_WAIT_Z -> next cycle all outputs 0, o_BUSY=0, no o_REQn_Z_STB ever asserted for the aborted request.
